// File: rtl/ula_n.sv
// rtl/ula_n.sv - registered ALU with optional iterative unsigned multiplier
//
// Purpose: accepts one request (a, b, op) per in_valid/in_ready handshake and
// returns a registered result with carry/zero/negative/overflow flags.
// Single-cycle ops answer on the edge after acceptance. With ULA_MUL_EN
// defined, op 9 runs a WIDTH-step shift-and-add multiply and holds off new
// requests until its result strobe.
//
// Configuration macro: ULA_MUL_EN (undefined by default -> op 9 is undefined)
//
// Ports:
//   clk        in   clock, rising edge
//   rst        in   asynchronous active-low reset
//   in_valid   in   request qualifier
//   in_ready   out  block can accept a request
//   a, b       in   WIDTH-bit operands
//   op         in   4-bit opcode
//   out_valid  out  one-cycle result strobe
//   out_ula    out  registered WIDTH-bit result
//   carry, zero, negative, overflow  out  registered flags
module ula_n #(
  parameter int WIDTH = 8,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       op,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_ula,
  output logic             carry,
  output logic             zero,
  output logic             negative,
  output logic             overflow
);

  localparam logic [3:0] OP_ADD = 4'd1;
  localparam logic [3:0] OP_SUB = 4'd2;
  localparam logic [3:0] OP_AND = 4'd3;
  localparam logic [3:0] OP_OR  = 4'd4;
  localparam logic [3:0] OP_NOT = 4'd5;
  localparam logic [3:0] OP_XOR = 4'd6;
  localparam logic [3:0] OP_SHL = 4'd7;
  localparam logic [3:0] OP_SHR = 4'd8;
`ifdef ULA_MUL_EN
  localparam logic [3:0] OP_MUL = 4'd9;
`endif

  logic w_accept;
  logic w_start_mul;

  assign w_accept = in_valid & in_ready;

`ifdef ULA_MUL_EN
  assign w_start_mul = w_accept && (op == OP_MUL);
`else
  assign w_start_mul = 1'b0;
`endif

  // Single-cycle requests are captured here so that operand changes after
  // acceptance cannot reach the result computed on the following edge.
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [3:0]       r_op;
  logic             r_pend;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_a    <= '0;
      r_b    <= '0;
      r_op   <= '0;
      r_pend <= 1'b0;
    end else begin
      r_pend <= w_accept & ~w_start_mul;
      if (w_accept & ~w_start_mul) begin
        r_a  <= a;
        r_b  <= b;
        r_op <= op;
      end
    end
  end

  // Combinational ALU on the captured request
  logic [SHW-1:0]   w_sh;
  logic [WIDTH:0]   w_add;
  logic [WIDTH:0]   w_sub;
  logic [WIDTH:0]   w_shl;
  logic [WIDTH:0]   w_shr;
  logic [WIDTH-1:0] w_res;
  logic             w_cy;
  logic             w_ov;

  assign w_sh  = r_b[SHW-1:0];
  assign w_add = {1'b0, r_a} + {1'b0, r_b};
  assign w_sub = {1'b0, r_a} - {1'b0, r_b};
  // One guard bit beyond the word catches the last bit shifted out:
  // bit WIDTH for left shifts, bit 0 for right shifts (zero when w_sh==0).
  assign w_shl = {1'b0, r_a} << w_sh;
  assign w_shr = {r_a, 1'b0} >> w_sh;

  always_comb begin
    w_res = '0;
    w_cy  = 1'b0;
    w_ov  = 1'b0;
    case (r_op)
      OP_ADD: begin
        w_res = w_add[WIDTH-1:0];
        w_cy  = w_add[WIDTH];
        w_ov  = (r_a[WIDTH-1] == r_b[WIDTH-1]) && (w_add[WIDTH-1] != r_a[WIDTH-1]);
      end
      OP_SUB: begin
        w_res = w_sub[WIDTH-1:0];
        w_cy  = w_sub[WIDTH];
        w_ov  = (r_a[WIDTH-1] != r_b[WIDTH-1]) && (w_sub[WIDTH-1] != r_a[WIDTH-1]);
      end
      OP_AND: w_res = r_a & r_b;
      OP_OR:  w_res = r_a | r_b;
      OP_NOT: w_res = ~r_b;
      OP_XOR: w_res = r_a ^ r_b;
      OP_SHL: begin
        w_res = w_shl[WIDTH-1:0];
        w_cy  = w_shl[WIDTH];
      end
      OP_SHR: begin
        w_res = w_shr[WIDTH:1];
        w_cy  = w_shr[0];
      end
      default: ;
    endcase
  end

`ifdef ULA_MUL_EN
  typedef enum logic {
    S_IDLE,
    S_MUL
  } state_t;

  localparam int CW = $clog2(WIDTH + 1);

  state_t             r_state;
  state_t             w_state_next;
  logic               w_mul_done;
  logic [2*WIDTH-1:0] r_mcand;
  logic [2*WIDTH-1:0] r_acc;
  logic [WIDTH-1:0]   r_mplier;
  logic [CW-1:0]      r_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // WIDTH iteration edges, then one more edge to publish the product,
  // which puts the strobe WIDTH+1 edges after acceptance.
  always_comb begin
    w_state_next = r_state;
    w_mul_done   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_start_mul) w_state_next = S_MUL;
      end
      S_MUL: begin
        if (r_cnt == CW'(WIDTH)) begin
          w_mul_done   = 1'b1;
          w_state_next = S_IDLE;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  assign in_ready = (r_state == S_IDLE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_mcand  <= '0;
      r_acc    <= '0;
      r_mplier <= '0;
      r_cnt    <= '0;
    end else if (w_start_mul) begin
      r_mcand  <= {{WIDTH{1'b0}}, a};
      r_acc    <= '0;
      r_mplier <= b;
      r_cnt    <= '0;
    end else if ((r_state == S_MUL) && !w_mul_done) begin
      if (r_mplier[0]) r_acc <= r_acc + r_mcand;
      r_mcand  <= r_mcand << 1;
      r_mplier <= r_mplier >> 1;
      r_cnt    <= r_cnt + CW'(1);
    end
  end
`else
  assign in_ready = 1'b1;
`endif

  // Result and flag registers hold between strobes
  logic             r_out_valid;
  logic [WIDTH-1:0] r_out_ula;
  logic             r_carry;
  logic             r_zero;
  logic             r_negative;
  logic             r_overflow;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_out_valid <= 1'b0;
      r_out_ula   <= '0;
      r_carry     <= 1'b0;
      r_zero      <= 1'b0;
      r_negative  <= 1'b0;
      r_overflow  <= 1'b0;
    end else begin
      r_out_valid <= 1'b0;
      if (r_pend) begin
        r_out_valid <= 1'b1;
        r_out_ula   <= w_res;
        r_carry     <= w_cy;
        r_zero      <= (w_res == '0);
        r_negative  <= w_res[WIDTH-1];
        r_overflow  <= w_ov;
      end
`ifdef ULA_MUL_EN
      else if (w_mul_done) begin
        r_out_valid <= 1'b1;
        r_out_ula   <= r_acc[WIDTH-1:0];
        r_carry     <= |r_acc[2*WIDTH-1:WIDTH];
        r_zero      <= (r_acc[WIDTH-1:0] == '0);
        r_negative  <= r_acc[WIDTH-1];
        r_overflow  <= 1'b0;
      end
`endif
    end
  end

  assign out_valid = r_out_valid;
  assign out_ula   = r_out_ula;
  assign carry     = r_carry;
  assign zero      = r_zero;
  assign negative  = r_negative;
  assign overflow  = r_overflow;

endmodule

// File: tb/tb_ula_n.sv
// tb/tb_ula_n.sv - scoreboard testbench for ula_n at WIDTH=8 and WIDTH=16
module tb_ula_n;

`ifdef ULA_MUL_EN
  localparam bit MUL_EN = 1'b1;
`else
  localparam bit MUL_EN = 1'b0;
`endif

  typedef struct packed {
    logic [15:0] res;
    logic        c;
    logic        z;
    logic        n;
    logic        v;
    logic [31:0] cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst;

  logic        in_valid8, in_ready8, out_valid8;
  logic [7:0]  a8, b8, out_ula8;
  logic [3:0]  op8;
  logic        carry8, zero8, negative8, overflow8;

  logic        in_valid16, in_ready16, out_valid16;
  logic [15:0] a16, b16, out_ula16;
  logic [3:0]  op16;
  logic        carry16, zero16, negative16, overflow16;

  ula_n #(.WIDTH(8)) u8 (
    .clk(clk), .rst(rst), .in_valid(in_valid8), .in_ready(in_ready8),
    .a(a8), .b(b8), .op(op8), .out_valid(out_valid8), .out_ula(out_ula8),
    .carry(carry8), .zero(zero8), .negative(negative8), .overflow(overflow8)
  );

  ula_n #(.WIDTH(16)) u16 (
    .clk(clk), .rst(rst), .in_valid(in_valid16), .in_ready(in_ready16),
    .a(a16), .b(b16), .op(op16), .out_valid(out_valid16), .out_ula(out_ula16),
    .carry(carry16), .zero(zero16), .negative(negative16), .overflow(overflow16)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int   n_assert = 0;
  int   n_fail   = 0;
  exp_t q8[$];
  exp_t q16[$];
  exp_t m8, m16, last8, last16;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t mk(input logic [15:0] r, input logic c, input logic z,
                              input logic n, input logic v);
    exp_t e;
    e = '0;
    e.res = r; e.c = c; e.z = z; e.n = n; e.v = v;
    return e;
  endfunction

  // Reference arithmetic on wide integers, masked to the operand width
  function automatic exp_t model(input int w, input logic [3:0] o,
                                 input logic [31:0] x, input logic [31:0] y);
    exp_t e;
    longint unsigned mask, msb, xl, yl, full, res, sh;
    e    = '0;
    mask = (64'd1 << w) - 1;
    msb  = 64'd1 << (w - 1);
    xl   = 64'(x) & mask;
    yl   = 64'(y) & mask;
    sh   = yl % 64'(w);
    res  = 0;
    case (o)
      4'd1: begin
        full = xl + yl;
        res  = full & mask;
        e.c  = ((full >> w) & 1) != 0;
        e.v  = ((xl & msb) == (yl & msb)) && ((res & msb) != (xl & msb));
      end
      4'd2: begin
        res = (xl - yl) & mask;
        e.c = xl < yl;
        e.v = ((xl & msb) != (yl & msb)) && ((res & msb) != (xl & msb));
      end
      4'd3: res = xl & yl;
      4'd4: res = xl | yl;
      4'd5: res = ~yl & mask;
      4'd6: res = xl ^ yl;
      4'd7: begin
        res = (xl << sh) & mask;
        e.c = (sh != 0) && (((xl >> (64'(w) - sh)) & 1) != 0);
      end
      4'd8: begin
        res = xl >> sh;
        e.c = (sh != 0) && (((xl >> (sh - 1)) & 1) != 0);
      end
      4'd9: begin
        if (MUL_EN) begin
          full = xl * yl;
          res  = full & mask;
          e.c  = (full >> w) != 0;
        end
      end
      default: res = 0;
    endcase
    e.res = res[15:0];
    e.z   = (res == 0);
    e.n   = ((res >> (w - 1)) & 1) != 0;
    return e;
  endfunction

  function automatic int lat(input int w, input logic [3:0] o);
    return (MUL_EN && o == 4'd9) ? w + 1 : 1;
  endfunction

  // Called just after a negedge: request is accepted on the coming posedge
  task automatic drive_now(input bit wide, input logic [3:0] o, input logic [15:0] x,
                           input logic [15:0] y, input exp_t e);
    e.cyc = 32'(cyc + 1 + 32'(lat(wide ? 16 : 8, o)));
    if (!wide) begin
      chk("u8 in_ready at request", 32'(in_ready8), 32'd1);
      q8.push_back(e);
      in_valid8 = 1'b1; op8 = o; a8 = x[7:0]; b8 = y[7:0];
    end else begin
      chk("u16 in_ready at request", 32'(in_ready16), 32'd1);
      q16.push_back(e);
      in_valid16 = 1'b1; op16 = o; a16 = x; b16 = y;
    end
    @(posedge clk);
    #1;
    in_valid8  = 1'b0;
    in_valid16 = 1'b0;
    a8  = 8'($urandom);  b8  = 8'($urandom);  op8  = 4'($urandom);
    a16 = 16'($urandom); b16 = 16'($urandom); op16 = 4'($urandom);
  endtask

  task automatic send(input bit wide, input logic [3:0] o, input logic [15:0] x,
                      input logic [15:0] y, input exp_t e);
    @(negedge clk);
    drive_now(wide, o, x, y, e);
  endtask

  task automatic send_model(input bit wide, input logic [3:0] o, input logic [15:0] x,
                            input logic [15:0] y);
    send(wide, o, x, y, model(wide ? 16 : 8, o, 32'(x), 32'(y)));
  endtask

  task automatic wait_drain(input string tag);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      #1;
      if (q8.size() == 0 && q16.size() == 0) break;
    end
    chk(tag, 32'(q8.size() + q16.size()), 32'd0);
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, " u8 out_valid"}, 32'(out_valid8), 32'd0);
    chk({tag, " u8 out_ula"},   32'(out_ula8),   32'd0);
    chk({tag, " u8 carry"},     32'(carry8),     32'd0);
    chk({tag, " u8 zero"},      32'(zero8),      32'd0);
    chk({tag, " u8 negative"},  32'(negative8),  32'd0);
    chk({tag, " u8 overflow"},  32'(overflow8),  32'd0);
    chk({tag, " u8 in_ready"},  32'(in_ready8),  32'd1);
    chk({tag, " u16 out_valid"}, 32'(out_valid16), 32'd0);
    chk({tag, " u16 out_ula"},   32'(out_ula16),   32'd0);
    chk({tag, " u16 zero"},      32'(zero16),      32'd0);
    chk({tag, " u16 carry"},     32'(carry16),     32'd0);
    chk({tag, " u16 in_ready"},  32'(in_ready16),  32'd1);
  endtask

  // Output monitors: every strobe must match the oldest pending expectation
  always @(negedge clk) begin
    if (rst === 1'b1 && out_valid8 === 1'b1) begin
      chk("u8 out_valid expected", 32'(q8.size() != 0), 32'd1);
      if (q8.size() != 0) begin
        m8 = q8.pop_front();
        chk("u8 out_ula",  32'(out_ula8),  32'(m8.res[7:0]));
        chk("u8 carry",    32'(carry8),    32'(m8.c));
        chk("u8 zero",     32'(zero8),     32'(m8.z));
        chk("u8 negative", 32'(negative8), 32'(m8.n));
        chk("u8 overflow", 32'(overflow8), 32'(m8.v));
        chk("u8 latency",  cyc,            m8.cyc);
        last8 = m8;
      end
    end
    if (rst === 1'b1 && out_valid16 === 1'b1) begin
      chk("u16 out_valid expected", 32'(q16.size() != 0), 32'd1);
      if (q16.size() != 0) begin
        m16 = q16.pop_front();
        chk("u16 out_ula",  32'(out_ula16),  32'(m16.res));
        chk("u16 carry",    32'(carry16),    32'(m16.c));
        chk("u16 zero",     32'(zero16),     32'(m16.z));
        chk("u16 negative", 32'(negative16), 32'(m16.n));
        chk("u16 overflow", 32'(overflow16), 32'(m16.v));
        chk("u16 latency",  cyc,             m16.cyc);
        last16 = m16;
      end
    end
`ifndef ULA_MUL_EN
    chk("u8 in_ready constant",  32'(in_ready8),  32'd1);
    chk("u16 in_ready constant", 32'(in_ready16), 32'd1);
`endif
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0;
    in_valid8 = 1'b0; a8 = '0; b8 = '0; op8 = '0;
    in_valid16 = 1'b0; a16 = '0; b16 = '0; op16 = '0;
    #1;
    chk_reset("reset");
    repeat (2) @(negedge clk);
    rst = 1'b1;

    // First request on the first edge after release
    drive_now(1'b0, 4'd1, 16'h00FF, 16'h0001, mk(16'h0000, 1'b1, 1'b1, 1'b0, 1'b0));
    wait_drain("drain add ff+01");

    send(1'b0, 4'd2, 16'h0080, 16'h0001, mk(16'h007F, 1'b0, 1'b0, 1'b0, 1'b1));
    send(1'b0, 4'd2, 16'h0003, 16'h0005, mk(16'h00FE, 1'b1, 1'b0, 1'b1, 1'b0));
    wait_drain("drain sub pair");

    repeat (3) @(negedge clk);
    #1;
    chk("u8 hold out_ula", 32'(out_ula8), 32'(last8.res[7:0]));
    chk("u8 hold carry",   32'(carry8),   32'(last8.c));
    chk("u8 hold negative", 32'(negative8), 32'(last8.n));

    send(1'b1, 4'd7, 16'h8001, 16'h0001, mk(16'h0002, 1'b1, 1'b0, 1'b0, 1'b0));
    send(1'b1, 4'd8, 16'h0001, 16'h0001, mk(16'h0000, 1'b1, 1'b1, 1'b0, 1'b0));
    send(1'b1, 4'd15, 16'h1234, 16'h5678, mk(16'h0000, 1'b0, 1'b1, 1'b0, 1'b0));
    wait_drain("drain 16-bit shifts");

`ifdef ULA_MUL_EN
    send(1'b0, 4'd9, 16'h0010, 16'h0020, mk(16'h0000, 1'b1, 1'b1, 1'b0, 1'b0));
    // k counts edges since acceptance; ready only in the strobe cycle,
    // and ADD requests offered while busy must be dropped.
    for (int k = 0; k <= 9; k++) begin
      @(negedge clk);
      chk("u8 mul in_ready", 32'(in_ready8), 32'(k == 9));
      in_valid8 = (k >= 2 && k <= 5);
      op8 = 4'd1; a8 = 8'h01; b8 = 8'h01;
    end
    drive_now(1'b0, 4'd1, 16'h0007, 16'h0008, mk(16'h000F, 1'b0, 1'b0, 1'b0, 1'b0));
    wait_drain("drain mul back-to-back");
    send_model(1'b0, 4'd9, 16'h00FF, 16'h00FF);
    wait_drain("drain mul ff*ff");
    send_model(1'b1, 4'd9, 16'h0123, 16'h0045);
    wait_drain("drain mul16");
`else
    send(1'b0, 4'd9, 16'h0003, 16'h0004, mk(16'h0000, 1'b0, 1'b1, 1'b0, 1'b0));
    wait_drain("drain op9 undefined");
`endif

    for (int i = 0; i < 16; i++) begin
      send_model(1'b0, 4'($urandom_range(0, 15)), 16'($urandom), 16'($urandom));
      wait_drain("drain random u8");
    end
    for (int i = 0; i < 10; i++) begin
      send_model(1'b1, 4'($urandom_range(0, 15)), 16'($urandom), 16'($urandom));
      wait_drain("drain random u16");
    end

    // Reset in the middle of work (mid-multiply when the multiplier exists)
`ifdef ULA_MUL_EN
    send_model(1'b0, 4'd9, 16'h00FF, 16'h00FF);
    repeat (4) @(negedge clk);
`else
    send_model(1'b0, 4'd6, 16'h00A5, 16'h003C);
    wait_drain("drain before reset");
    @(negedge clk);
`endif
    #2;
    rst = 1'b0;
    #1;
    chk_reset("mid reset");
    q8.delete();
    q16.delete();
    repeat (2) @(negedge clk);
    rst = 1'b1;
    drive_now(1'b0, 4'd1, 16'h0002, 16'h0003, mk(16'h0005, 1'b0, 1'b0, 1'b0, 1'b0));
    wait_drain("drain add after reset");
    repeat (20) @(negedge clk);
    #1;
    chk("final queues empty", 32'(q8.size() + q16.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
